// File: rtl/round_pkg.sv
// Shared types for the mantissa rounder: rounding-mode encoding and Galois LFSR taps.
package round_pkg;

    typedef enum logic [2:0] {
        RND_RNE = 3'd0,
        RND_RTZ = 3'd1,
        RND_RUP = 3'd2,
        RND_RDN = 3'd3,
        RND_RNA = 3'd4,
        RND_SR  = 3'd5
    } round_mode_e;

    // Right-shifting Galois feedback masks giving maximal-length sequences.
    function automatic logic [31:0] lfsr_taps(input int unsigned width);
        logic [31:0] taps;
        case (width)
            2:       taps = 32'h0000_0003;
            3:       taps = 32'h0000_0006;
            4:       taps = 32'h0000_000C;
            5:       taps = 32'h0000_0014;
            6:       taps = 32'h0000_0030;
            7:       taps = 32'h0000_0060;
            8:       taps = 32'h0000_00B8;
            9:       taps = 32'h0000_0110;
            10:      taps = 32'h0000_0240;
            11:      taps = 32'h0000_0500;
            12:      taps = 32'h0000_0E08;
            13:      taps = 32'h0000_1C80;
            14:      taps = 32'h0000_3802;
            15:      taps = 32'h0000_6000;
            16:      taps = 32'h0000_B400;
            default: taps = 32'h0000_00B8;
        endcase
        return taps;
    endfunction

endpackage

// File: rtl/round_lfsr.sv
// Galois LFSR supplying random bits for stochastic rounding; steps once per adv pulse.
module round_lfsr
    import round_pkg::*;
#(
    parameter int unsigned width = 8,
    parameter int unsigned seed  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adv,
    output logic [width-1:0] rnd
);

    localparam logic [width-1:0] taps = width'(lfsr_taps(width));

    always_ff @(posedge clk) begin
        if (rst) begin
            rnd <= width'(seed);
        end else if (adv) begin
            rnd <= (rnd >> 1) ^ (rnd[0] ? taps : '0);
        end
    end

endmodule

// File: rtl/round_pipe.sv
// Two-stage multi-mode mantissa rounder with valid/ready flow control.
// Define SR_LFSR_EN to source stochastic-rounding bits from an internal LFSR instead of rand_in.
module round_pipe
    import round_pkg::*;
#(
    parameter int unsigned mant_width     = 23,
    parameter int unsigned num_round_bits = 8,
    parameter int unsigned lfsr_seed      = 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [2:0]                           mode,
    input  logic                                 sign,
    input  logic [mant_width+num_round_bits-1:0] mantissa_in,
    input  logic                                 sticky_in,
    input  logic [num_round_bits-1:0]            rand_in,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [mant_width:0]                  rounded,
    output logic                                 carry_out,
    output logic                                 inexact
);

    logic                                 adv;
    logic                                 accept;
    logic [num_round_bits-1:0]            rand_src;

    logic                                 s1_valid;
    round_mode_e                          s1_mode;
    logic                                 s1_sign;
    logic [mant_width+num_round_bits-1:0] s1_mant;
    logic                                 s1_sticky;
    logic [num_round_bits-1:0]            s1_rand;

    logic [mant_width-1:0]                m;
    logic [num_round_bits-1:0]            r;
    logic                                 g;
    logic                                 rest;
    logic                                 lsb;
    logic                                 inex;
    logic [num_round_bits:0]              sr_sum;
    logic                                 inc;
    logic [mant_width:0]                  rounded_nxt;

    // A stalled output freezes the whole pipe, so one enable drives both stages.
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;
    assign accept   = in_valid & adv;

`ifdef SR_LFSR_EN
    round_lfsr #(
        .width (num_round_bits),
        .seed  (lfsr_seed)
    ) u_lfsr (
        .clk (clk),
        .rst (rst),
        .adv (accept),
        .rnd (rand_src)
    );
`else
    assign rand_src = rand_in;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (adv) begin
            s1_valid  <= in_valid;
            s1_mode   <= round_mode_e'(mode);
            s1_sign   <= sign;
            s1_mant   <= mantissa_in;
            s1_sticky <= sticky_in;
            s1_rand   <= rand_src;
        end
    end

    assign m      = s1_mant[mant_width+num_round_bits-1:num_round_bits];
    assign r      = s1_mant[num_round_bits-1:0];
    assign g      = r[num_round_bits-1];
    assign rest   = (|r[num_round_bits-2:0]) | s1_sticky;
    assign lsb    = m[0];
    assign inex   = (|r) | s1_sticky;
    assign sr_sum = {1'b0, r} + {1'b0, s1_rand};

    always_comb begin
        inc = 1'b0;
        case (s1_mode)
            RND_RTZ: inc = 1'b0;
            RND_RUP: inc = ~s1_sign & inex;
            RND_RDN: inc = s1_sign & inex;
            RND_RNA: inc = g;
            RND_SR:  inc = sr_sum[num_round_bits];
            default: inc = g & (rest | lsb);
        endcase
    end

    assign rounded_nxt = {1'b0, m} + {{mant_width{1'b0}}, inc};

    // Bubbles load zeros so an invalid output never raises carry or inexact.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            rounded   <= '0;
            inexact   <= 1'b0;
        end else if (adv) begin
            out_valid <= s1_valid;
            rounded   <= s1_valid ? rounded_nxt : '0;
            inexact   <= s1_valid & inex;
        end
    end

    assign carry_out = rounded[mant_width];

endmodule

// File: tb/tb_round_pipe.sv
// Scoreboard bench for round_pipe (mant_width=4, num_round_bits=4, default build).
module tb_round_pipe;

    localparam int unsigned MW  = 4;
    localparam int unsigned NRB = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [2:0]     mode;
    logic           sign;
    logic [MW+NRB-1:0] mantissa_in;
    logic           sticky_in;
    logic [NRB-1:0] rand_in;
    logic           out_valid;
    logic           out_ready;
    logic [MW:0]    rounded;
    logic           carry_out;
    logic           inexact;

    always #5 clk = ~clk;

    round_pipe #(
        .mant_width     (MW),
        .num_round_bits (NRB),
        .lfsr_seed      (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .mode        (mode),
        .sign        (sign),
        .mantissa_in (mantissa_in),
        .sticky_in   (sticky_in),
        .rand_in     (rand_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .rounded     (rounded),
        .carry_out   (carry_out),
        .inexact     (inexact)
    );

    typedef struct {
        logic [4:0] rnd;
        logic       inex;
        int         cyc;
        bit         lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   popped = 0;
    bit   rdy_rand = 1'b0;
    logic rdy_val  = 1'b1;

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_val;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Rounding rules in plain integer arithmetic; returns {inexact, rounded}.
    function automatic logic [5:0] model(input logic [2:0] md, input logic sg, input logic [7:0] x,
                                         input logic st, input logic [3:0] rn);
        int m = int'(x) / 16;
        int r = int'(x) % 16;
        bit ix = (r != 0) || st;
        bit up;
        case (md)
            3'd1:    up = 1'b0;
            3'd2:    up = !sg && ix;
            3'd3:    up = sg && ix;
            3'd4:    up = r >= 8;
            3'd5:    up = (r + int'(rn)) >= 16;
            default: up = (r > 8) || (r == 8 && (st || (m % 2) == 1));
        endcase
        return {ix, 5'(m + int'(up))};
    endfunction

    task automatic send(input logic [2:0] md, input logic sg, input logic [7:0] x, input logic st,
                        input logic [3:0] rn, input bit use_exp, input logic [5:0] expv, input bit lat);
        logic [5:0] e;
        bit done = 1'b0;
        in_valid    = 1'b1;
        mode        = md;
        sign        = sg;
        mantissa_in = x;
        sticky_in   = st;
        rand_in     = rn;
        e = use_exp ? expv : model(md, sg, x, st, rn);
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back('{e[4:0], e[5], cyc, lat});
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready=0 for 200 cycles expected acceptance");
        end
        in_valid    = 1'b0;
        mantissa_in = 8'($urandom);
        mode        = 3'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_empty", sb.size(), 0);
    endtask

    logic [4:0] h_rnd;
    logic       h_inex;
    logic       h_carry;
    bit         stalled = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            check("in_ready_rule", in_ready, !out_valid || out_ready);
            if (stalled) begin
                check("hold_valid", out_valid, 1);
                check("hold_rounded", rounded, h_rnd);
                check("hold_inexact", inexact, h_inex);
                check("hold_carry", carry_out, h_carry);
            end
            stalled = out_valid && !out_ready;
            h_rnd   = rounded;
            h_inex  = inexact;
            h_carry = carry_out;
            if (!out_valid) begin
                check("idle_inexact", inexact, 0);
                check("idle_carry", carry_out, 0);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got rounded=%0h expected no output", rounded);
                end else begin
                    e = sb.pop_front();
                    popped++;
                    check("rounded", rounded, e.rnd);
                    check("inexact", inexact, e.inex);
                    check("carry_out", carry_out, e.rnd[4]);
                    if (e.lat) check("latency", cyc - e.cyc, 2);
                end
            end
        end else begin
            stalled = 1'b0;
        end
    end

    // {mode, sign, mantissa_in, sticky, rand, expected {inexact, rounded}}
    typedef struct {
        logic [2:0] md;
        logic       sg;
        logic [7:0] x;
        logic       st;
        logic [3:0] rn;
        logic [5:0] ex;
    } vec_t;

    vec_t vecs[$] = '{
        '{3'd0, 1'b0, 8'h18, 1'b0, 4'h0, 6'h22},
        '{3'd0, 1'b0, 8'h28, 1'b0, 4'h0, 6'h22},
        '{3'd0, 1'b0, 8'h29, 1'b0, 4'h0, 6'h23},
        '{3'd0, 1'b0, 8'h08, 1'b1, 4'h0, 6'h21},
        '{3'd1, 1'b0, 8'hFF, 1'b0, 4'h0, 6'h2F},
        '{3'd2, 1'b0, 8'hF1, 1'b0, 4'h0, 6'h30},
        '{3'd2, 1'b1, 8'hF1, 1'b0, 4'h0, 6'h2F},
        '{3'd3, 1'b0, 8'hF1, 1'b0, 4'h0, 6'h2F},
        '{3'd3, 1'b1, 8'hF1, 1'b0, 4'h0, 6'h30},
        '{3'd4, 1'b0, 8'h08, 1'b0, 4'h0, 6'h21},
        '{3'd5, 1'b0, 8'h08, 1'b0, 4'h8, 6'h21},
        '{3'd5, 1'b0, 8'h08, 1'b0, 4'h7, 6'h20},
        '{3'd6, 1'b0, 8'h18, 1'b0, 4'h0, 6'h22},
        '{3'd7, 1'b0, 8'h29, 1'b0, 4'h0, 6'h23}
    };

    initial begin
        bit ok;
        int base;
        rst = 1'b1;
        in_valid = 1'b0;
        mode = '0;
        sign = 1'b0;
        mantissa_in = '0;
        sticky_in = 1'b0;
        rand_in = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_rounded", rounded, 0);
        check("rst_carry", carry_out, 0);
        check("rst_inexact", inexact, 0);
        check("rst_in_ready", in_ready, 1);

        foreach (vecs[i])
            send(vecs[i].md, vecs[i].sg, vecs[i].x, vecs[i].st, vecs[i].rn, 1'b1, vecs[i].ex, 1'b1);
        for (int md = 0; md < 8; md++)
            send(3'(md), md[0], 8'h30, 1'b0, 4'hF, 1'b1, 6'h03, 1'b1);
        drain();

        // Backpressure: stall three cycles once the first result shows up.
        base = popped;
        fork
            begin
                for (int i = 0; i < 4; i++)
                    send(3'($urandom_range(0, 7)), 1'($urandom), 8'($urandom), 1'($urandom),
                         4'($urandom), 1'b0, 6'h0, 1'b0);
            end
            begin
                ok = 1'b0;
                for (int i = 0; i < 50 && !ok; i++) begin
                    @(negedge clk);
                    ok = out_valid;
                end
                check("bp_first_valid", ok, 1);
                @(posedge clk);
                rdy_val = 1'b0;
                repeat (3) @(posedge clk);
                rdy_val = 1'b1;
            end
        join
        drain();
        check("bp_delivered", popped - base, 4);

        // Reset with two ops in flight: both must vanish.
        send(3'd0, 1'b0, 8'h29, 1'b0, 4'h0, 1'b0, 6'h0, 1'b0);
        send(3'd1, 1'b0, 8'hFF, 1'b0, 4'h0, 1'b0, 6'h0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_rounded", rounded, 0);
        repeat (4) @(posedge clk);
        #1;
        send(3'd2, 1'b0, 8'hF1, 1'b0, 4'h0, 1'b1, 6'h30, 1'b1);
        drain();

        // Randomized traffic under random backpressure.
        rdy_rand = 1'b1;
        for (int i = 0; i < 300; i++) begin
            send(3'($urandom_range(0, 7)), 1'($urandom), 8'($urandom), 1'($urandom_range(0, 3) == 0),
                 4'($urandom), 1'b0, 6'h0, 1'b0);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1;
            end
        end
        rdy_rand = 1'b0;
        rdy_val  = 1'b1;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected completion");
        $fatal(1);
    end

endmodule
